// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   - FSM state encoding for uart_tx_arbiter
//   - default end-of-line character and line-lock idle budget
//   - hold counter width and a saturating increment helper
package uart_pkg;

    localparam int         STATE_W    = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WAIT_LO = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    localparam logic [6:0] EOL_CHAR_DEFAULT    = 7'h0A;
    localparam int         LOCK_CYCLES_DEFAULT = 8192;

    localparam int                    HOLD_CNT_W   = 16;
    localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;

    // Counter increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
        return (v == HOLD_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority select.
//   req    : per-requester request vector
//   last   : index of the previously granted requester
//   winner : first requesting index after 'last', wrapping around
//   valid  : at least one request bit is set
module rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [1:0]       winner,
    output logic             valid
);

    logic [1:0] hi_idx;
    logic [1:0] lo_idx;
    logic       hi_hit;
    logic       lo_hit;

    // Split the requests into those above 'last' and those at or below it.
    // Scanning downward leaves the lowest index of each half; the upper half
    // wins, the lower half is the wrap-around (so 'last' itself comes last).
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(last)) begin
                    hi_hit = 1'b1;
                    hi_idx = 2'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = 2'(i);
                end
            end
        end
    end

    assign valid  = hi_hit | lo_hit;
    assign winner = hi_hit ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ requesters,
// round-robin per character, with a line lock that keeps the transmitter
// on one requester until it sends EOL_CHAR or idles for LOCK_CYCLES cycles.
//   clk, rst_n : system clock, asynchronous active-low reset
//   req, data  : per-requester valid and 7-bit character (requester i on [7i+6:7i])
//   ack        : one-cycle pulse, character of requester 'owner' accepted
//   tx_load    : load strobe to the transmitter, tx_data the character
//   tx_ready   : transmitter idle
//   owner      : current or last granted requester
//   locked     : line lock held by 'owner'
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         N_REQ       = 3,
    parameter logic [6:0] EOL_CHAR    = EOL_CHAR_DEFAULT,
    parameter int         LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_load,
    output logic [6:0]         tx_data,
    input  logic               tx_ready,
    output logic [1:0]         owner,
    output logic               locked
);

    // Reset owner to the last index so requester 0 is first in line.
    localparam logic [1:0] OWNER_RST = 2'(N_REQ - 1);
    // One bit wider than the counter so LOCK_CYCLES up to 65536 compares cleanly.
    localparam logic [HOLD_CNT_W:0] HOLD_LIMIT = (HOLD_CNT_W + 1)'(LOCK_CYCLES - 1);

    logic [STATE_W-1:0]    state;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [HOLD_CNT_W-1:0] hold_next;
    logic                  lock_spent;
    logic                  lock_last;

    logic [1:0] pick_idx;
    logic       pick_valid;
    logic [6:0] pick_data;
    logic [6:0] owner_data;
    logic       owner_req;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .last   (owner),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Character and request of the round-robin winner and of the lock owner.
    always_comb begin
        pick_data  = '0;
        owner_data = '0;
        owner_req  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (2'(i) == pick_idx) begin
                pick_data = data[7*i +: 7];
            end
            if (2'(i) == owner) begin
                owner_data = data[7*i +: 7];
                owner_req  = req[i];
            end
        end
    end

    assign hold_next = sat_inc(hold_cnt);
    // lock_spent only fires on HOLD entry when LOCK_CYCLES is 1 (no idle budget
    // at all); in that case the lock is released even if the owner is requesting.
    assign lock_spent = ({1'b0, hold_cnt}  >= HOLD_LIMIT);
    assign lock_last  = ({1'b0, hold_next} >= HOLD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= OWNER_RST;
            locked   <= 1'b0;
            tx_data  <= '0;
            hold_cnt <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch below sees the values from before this clock edge.
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_idx;
                        tx_data <= pick_data;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // No timeout: a busy transmitter just stretches the load.
                    if (tx_ready) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_ready) begin
                        state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_ready) begin
                        if (tx_data == EOL_CHAR) begin
                            locked <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            locked   <= 1'b1;
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (lock_spent) begin
                        locked <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (owner_req) begin
                        tx_data <= owner_data;
                        state   <= ST_LOAD;
                    end else begin
                        hold_cnt <= hold_next;
                        if (lock_last) begin
                            locked <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Both strobes decode straight from state, so the asynchronous reset
    // clears them in the same instant it forces IDLE.
    assign tx_load = (state == ST_LOAD);

    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tx_load && tx_ready && (2'(i) == owner)) begin
                ack[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a scoreboard.
// Main instance uses LOCK_CYCLES=20; a second instance with LOCK_CYCLES=1
// covers round-robin fairness under constant requests.
module tb_uart_tx_arbiter;

    localparam int         N     = 3;
    localparam int         LC    = 20;
    localparam int         FRAME = 10;
    localparam logic [6:0] EOL   = 7'h0A;

    typedef struct {
        int         idx;
        logic [6:0] ch;
    } exp_t;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [7*N-1:0] data  = '0;
    logic [N-1:0]   ack;
    logic           tx_load;
    logic [6:0]     tx_data;
    logic           tx_ready;
    logic [1:0]     owner;
    logic           locked;
    logic           hold_busy = 1'b0;
    int             busy_cnt;

    logic [N-1:0]   req_f  = '0;
    logic [7*N-1:0] data_f = {7'h63, 7'h62, 7'h61};
    logic [N-1:0]   ack_f;
    logic           tx_load_f;
    logic [6:0]     tx_data_f;
    logic           tx_ready_f;
    logic [1:0]     owner_f;
    logic           locked_f;
    int             busy_f;

    int   tests       = 0;
    int   fails       = 0;
    int   ack_count   = 0;
    int   ack_count_f = 0;
    int   cyc         = 0;
    exp_t sb_q[$];
    exp_t sbf_q[$];

    uart_tx_arbiter #(
        .N_REQ       (N),
        .EOL_CHAR    (EOL),
        .LOCK_CYCLES (LC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .tx_load  (tx_load),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .owner    (owner),
        .locked   (locked)
    );

    uart_tx_arbiter #(
        .N_REQ       (N),
        .EOL_CHAR    (EOL),
        .LOCK_CYCLES (1)
    ) dut_fair (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_f),
        .data     (data_f),
        .ack      (ack_f),
        .tx_load  (tx_load_f),
        .tx_data  (tx_data_f),
        .tx_ready (tx_ready_f),
        .owner    (owner_f),
        .locked   (locked_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for FRAME+1 cycles after an accepted load;
    // hold_busy forces it busy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready <= 1'b1;
            busy_cnt <= 0;
        end else if (hold_busy) begin
            tx_ready <= 1'b0;
        end else if (tx_ready && tx_load) begin
            tx_ready <= 1'b0;
            busy_cnt <= FRAME;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_ready <= 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_f <= 1'b1;
            busy_f     <= 0;
        end else if (tx_ready_f && tx_load_f) begin
            tx_ready_f <= 1'b0;
            busy_f     <= 4;
        end else if (busy_f != 0) begin
            busy_f <= busy_f - 1;
        end else begin
            tx_ready_f <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected character.
    always @(negedge clk) begin
        if (rst_n && ack != '0) begin
            exp_t e;
            ack_count++;
            check("ack_onehot", 32'($onehot(ack)), 32'd1);
            check("ack_with_load", 32'(tx_load), 32'd1);
            if (sb_q.size() == 0) begin
                check("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_bit", 32'(ack), 32'(1 << e.idx));
                check("ack_owner", 32'(owner), 32'(e.idx));
                check("ack_char", 32'(tx_data), 32'(e.ch));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ack_f != '0) begin
            exp_t e;
            ack_count_f++;
            check("fair_onehot", 32'($onehot(ack_f)), 32'd1);
            if (sbf_q.size() == 0) begin
                check("fair_unexpected", 32'(ack_f), 32'd0);
            end else begin
                e = sbf_q.pop_front();
                check("fair_order", 32'(owner_f), 32'(e.idx));
                check("fair_char", 32'(tx_data_f), 32'(e.ch));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_char(input int i, input logic [6:0] ch);
        data[7*i +: 7] = ch;
    endtask

    task automatic push(input int i, input logic [6:0] ch);
        sb_q.push_back('{idx: i, ch: ch});
    endtask

    task automatic wait_acks(input string tag, input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_ack_timeout"}, 32'(ack_count >= target), 32'd1);
    endtask

    task automatic wait_locked(input string tag, input logic val, input int budget);
        int n = 0;
        while (locked !== val && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_locked"}, 32'(locked), 32'(val));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t_fall;
        int t_grant;
        int bad;
        int base;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd2);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fair_owner", 32'(owner_f), 32'd2);
        rst_n = 1'b1;
        tick(2);
        check("idle_no_load", 32'(tx_load), 32'd0);

        // Single request, one-cycle latency
        set_char(0, 7'h41);
        req = 3'b001;
        push(0, 7'h41);
        tick();
        check("single_load", 32'(tx_load), 32'd1);
        check("single_ack", 32'(ack), 32'b001);
        check("single_data", 32'(tx_data), 32'h41);
        check("single_owner", 32'(owner), 32'd0);
        req = 3'b000;
        wait_acks("single", 1, 5);
        wait_locked("single_lock", 1'b1, 3 * FRAME);
        wait_locked("single_unlock", 1'b0, LC + 10);

        // Lock timeout: requester 2 sends 'X' and idles while req0 waits
        set_char(2, 7'h58);
        set_char(0, 7'h61);
        req = 3'b101;
        push(2, 7'h58);
        push(0, 7'h61);
        wait_acks("x", 2, 5);
        req[2] = 1'b0;
        wait_locked("x_lock", 1'b1, 3 * FRAME);
        t0 = cyc;
        t_fall = -1;
        t_grant = -1;
        for (int i = 0; i < LC + 10 && t_grant < 0; i++) begin
            tick();
            if (t_fall < 0 && locked === 1'b0) t_fall = cyc;
            if (tx_load === 1'b1) t_grant = cyc;
        end
        check("timeout_unlock_cycles", 32'(t_fall - t0), 32'(LC - 1));
        check("timeout_grant_cycles", 32'(t_grant - t0), 32'(LC));
        check("timeout_grant_owner", 32'(owner), 32'd0);
        wait_acks("a", 3, 5);
        req = 3'b000;
        wait_locked("a_lock", 1'b1, 3 * FRAME);
        wait_locked("a_unlock", 1'b0, LC + 10);

        // Line lock: requester 1 sends H, I, EOL while req0 waits
        set_char(0, 7'h7A);
        set_char(1, 7'h48);
        req = 3'b011;
        push(1, 7'h48);
        push(1, 7'h49);
        push(1, EOL);
        push(0, 7'h7A);
        tick();
        check("simul_owner", 32'(owner), 32'd1);
        check("simul_ack", 32'(ack), 32'b010);
        wait_acks("h", 4, 5);
        set_char(1, 7'h49);
        wait_acks("i", 5, 3 * FRAME);
        check("line_lock_held", 32'(locked), 32'd1);
        set_char(1, EOL);
        wait_acks("eol", 6, 3 * FRAME);
        req[1] = 1'b0;
        wait_acks("z", 7, 3 * FRAME);
        check("eol_released", 32'(locked), 32'd0);
        req = 3'b000;
        wait_locked("z_lock", 1'b1, 3 * FRAME);
        wait_locked("z_unlock", 1'b0, LC + 10);

        // Busy transmitter: 500 cycles of tx_ready=0 in LOAD
        hold_busy = 1'b1;
        set_char(2, 7'h42);
        req = 3'b100;
        push(2, 7'h42);
        tick();
        check("busy_load", 32'(tx_load), 32'd1);
        check("busy_ack_low", 32'(ack), 32'd0);
        bad = 0;
        repeat (499) begin
            tick();
            if (tx_load !== 1'b1 || ack !== 3'b000) bad++;
        end
        check("busy_hold_cycles", 32'(bad), 32'd0);
        check("busy_ack_count", 32'(ack_count), 32'd7);
        hold_busy = 1'b0;
        tick();
        check("busy_release_ack", 32'(ack), 32'b100);
        req = 3'b000;
        wait_locked("b_lock", 1'b1, 3 * FRAME);
        wait_locked("b_unlock", 1'b0, LC + 10);

        // Requester drops req after grant, before ack
        hold_busy = 1'b1;
        set_char(1, 7'h51);
        req = 3'b010;
        push(1, 7'h51);
        tick();
        check("drop_grant_load", 32'(tx_load), 32'd1);
        req = 3'b000;
        tick(3);
        check("drop_no_ack_yet", 32'(ack), 32'd0);
        hold_busy = 1'b0;
        wait_acks("drop", 9, 5);

        // Second character under lock, then reset in WAIT_HI
        set_char(1, 7'h52);
        req = 3'b010;
        push(1, 7'h52);
        wait_acks("r", 10, 3 * FRAME);
        req = 3'b000;
        tick(2);
        check("pre_rst_locked", 32'(locked), 32'd1);
        check("pre_rst_owner", 32'(owner), 32'd1);
        check("pre_rst_data", 32'(tx_data), 32'h52);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_load", 32'(tx_load), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        check("async_rst_owner", 32'(owner), 32'd2);
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_data", 32'(tx_data), 32'd0);
        tick(3);
        rst_n = 1'b1;
        base = ack_count;
        tick(30);
        check("no_stray_ack", 32'(ack_count), 32'(base));
        check("no_stray_load", 32'(tx_load), 32'd0);

        // First grant after reset goes to index 0; requester 2 follows on timeout
        set_char(0, 7'h6B);
        set_char(2, 7'h6D);
        req = 3'b101;
        push(0, 7'h6B);
        push(2, 7'h6D);
        tick();
        check("post_rst_owner", 32'(owner), 32'd0);
        check("post_rst_ack", 32'(ack), 32'b001);
        req[0] = 1'b0;
        wait_acks("m", base + 2, LC + 4 * FRAME);
        req = 3'b000;
        wait_locked("m_lock", 1'b1, 3 * FRAME);
        wait_locked("m_unlock", 1'b0, LC + 10);

        // Fairness with LOCK_CYCLES=1 and all requests held
        sbf_q.push_back('{idx: 0, ch: 7'h61});
        sbf_q.push_back('{idx: 1, ch: 7'h62});
        sbf_q.push_back('{idx: 2, ch: 7'h63});
        sbf_q.push_back('{idx: 0, ch: 7'h61});
        req_f = 3'b111;
        for (int i = 0; i < 200 && ack_count_f < 4; i++) tick();
        req_f = 3'b000;
        check("fair_ack_timeout", 32'(ack_count_f >= 4), 32'd1);
        tick(40);
        check("fair_total_acks", 32'(ack_count_f), 32'd4);
        check("fair_sb_empty", 32'(sbf_q.size()), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_ack_count", 32'(ack_count), 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requester ports (2..4).
REQ-002 SHALL have parameter EOL_CHAR, default 7'h0A, the character that releases a line lock.
REQ-003 SHALL have parameter LOCK_CYCLES, default 8192, the idle cycles an owner may hold the lock between characters.
REQ-004 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester character-valid.
REQ-007 SHALL have port data  input  7*N_REQ  per-requester 7-bit character; requester i drives bits [7i+6:7i].
REQ-008 SHALL have port ack  output  N_REQ  one-cycle pulse; the character of requester i has been accepted.
REQ-009 SHALL have port tx_load  output  1  load strobe to the UART transmitter.
REQ-010 SHALL have port tx_data  output  7  character presented to the transmitter.
REQ-011 SHALL have port tx_ready  input  1  transmitter idle; drops the cycle after an accepted load and rises when the stop bit ends.
REQ-012 SHALL have port owner  output  2  index of the current or last granted requester.
REQ-013 SHALL have port locked  output  1  high while a line lock is held.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT_LO, WAIT_HI and HOLD.
REQ-015 In IDLE with any req bit high, the arbiter SHALL grant round-robin, starting at index owner+1 mod N_REQ. It SHALL register the winner into owner, capture its data into tx_data, and go to LOAD.
REQ-016 In LOAD, tx_load SHALL be high and stay high until a cycle in which tx_ready=1.
REQ-017 In that cycle, ack[owner] SHALL pulse and the FSM SHALL go to WAIT_LO.
REQ-018 tx_load and ack SHALL be high only in LOAD with tx_ready=1 for ack; at most one ack bit SHALL be high in any cycle.
REQ-019 The FSM SHALL leave WAIT_LO for WAIT_HI when tx_ready=0, and leave WAIT_HI when tx_ready=1.
REQ-020 On leaving WAIT_HI: if the sent character equals EOL_CHAR, the FSM SHALL clear locked and go to IDLE. Otherwise it SHALL set locked, clear the hold counter and go to HOLD.
REQ-021 In HOLD with req[owner]=1, the FSM SHALL capture data[owner] and go to LOAD; requests from other requesters SHALL be ignored.
REQ-022 In HOLD with req[owner]=0, the hold counter SHALL increment. When it reaches LOCK_CYCLES-1, the FSM SHALL clear locked and go to IDLE.
REQ-023 The hold counter SHALL be 16 bits and SHALL saturate, never wrap.
REQ-024 Latency: req rising in IDLE with tx_ready=1 -> tx_load and ack one cycle later.
REQ-025 A requester SHALL hold req and data stable until it receives ack. The arbiter SHALL NOT re-sample data after capture.
REQ-026 A requester dropping req after grant but before ack SHALL NOT abort the transfer; the captured character SHALL be sent and acked.
REQ-027 Simultaneous requests: exactly one SHALL be granted; the others SHALL wait with no ack.
REQ-028 If tx_ready is low on entry to LOAD, the arbiter SHALL wait in LOAD without a timeout.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, owner=N_REQ-1 (so index 0 wins first), locked=0, tx_load=0, ack=0, tx_data=0 and hold counter=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer and discard any character not yet acked; no ack SHALL be issued after rst_n rises until a new grant.
REQ-031 Reset deassertion SHALL be taken synchronously to clk by the integrating top level; this block needs no internal reset synchronizer.

Structure
REQ-032 State encoding, EOL_CHAR and the LOCK_CYCLES default SHALL live in a shared package, uart_pkg.
REQ-033 The round-robin priority select SHALL be one sub-module, rr_pick: inputs req and last owner; outputs winner index and a valid flag.
REQ-034 The UART transmitter SHALL be instantiated outside this block, with tx_load, tx_data and tx_ready wired point-to-point.

Verification
REQ-035 Single request: req=001, data0=7'h41, tx_ready=1 -> tx_load and ack=001 next cycle, tx_data=7'h41, owner=0.
REQ-036 Fairness: req=111 held, characters not EOL, LOCK_CYCLES=1 -> grant order 0,1,2,0, with one ack per completed character.
REQ-037 Line lock: requester 1 sends 'H','I',7'h0A while req0 is high -> requester 0 gets its first ack only after the 7'h0A frame completes.
REQ-038 Lock timeout: requester 2 sends 'X' then idles, req0=1 -> locked falls and requester 0 is granted exactly LOCK_CYCLES cycles after WAIT_HI exits.
REQ-039 Busy transmitter: tx_ready=0 for 500 cycles on entry to LOAD -> tx_load stays high with no ack; ack comes in the first cycle tx_ready=1.
REQ-040 Reset mid-frame: rst_n low during WAIT_HI -> all outputs at reset values immediately (asynchronously); no stray ack after release.
